// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART transmitter with optional parity and one or two stop bits.
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic tx_n, rd_n, done_n, bit_end, last_data, last_stop;
  assign bit_end   = cnt == CW'(CLKS_PER_BIT - 1);
  assign last_data = idx == IW'(DATA_WIDTH - 1);
  assign last_stop = idx == IW'(STOP_BITS - 1);
  assign busy      = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
      fifo_rd <= rd_n;
      tx_done <= done_n;
    end
  end
  // idx counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt + CW'(1);
    idx_n   = idx;
    shreg_n = shreg;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (enable && !fifo_empty) begin
          state_n = START;
          shreg_n = fifo_data;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (bit_end) begin
        idx_n   = last_data ? '0 : idx + IW'(1);
        state_n = !last_data ? DATA : PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: if (bit_end) begin
        idx_n   = last_stop ? '0 : idx + IW'(1);
        state_n = last_stop ? IDLE : STOP;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered, so they are decoded from the next state
  always_comb begin
    tx_n   = state_n == START  ? 1'b0 :
             state_n == DATA   ? shreg_n[idx_n] :
             state_n == PARITY ? (^shreg) ^ (PARITY_ODD != 0) : 1'b1;
    rd_n   = state == IDLE && state_n == START;
    done_n = state == STOP && state_n == IDLE;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, FIFO handshake, stalls and reset.
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst, fifo_empty;
  logic [7:0] fifo_data;
  logic [3:0] en_v, rd_v, tx_v, busy_v, done_v;
  int passed = 0, total = 0, cyc = 0, rd_bad = 0;
  int rd_total [4] = '{0, 0, 0, 0};
  int last_rd = 0, prev_rd = 0;
  logic [7:0] q [$];
  logic [15:0] cap_bits;
  int cap_glitch, cap_busy, cap_rd, cap_done;
  logic end_tx, end_done, end_busy;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4)) u0 (.clk(clk), .rst(rst), .enable(en_v[0]), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (.clk(clk), .rst(rst), .enable(en_v[1]), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .enable(en_v[2]),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]),
    .tx_done(done_v[2]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .enable(en_v[3]),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(rd_v[3]), .tx(tx_v[3]), .busy(busy_v[3]),
    .tx_done(done_v[3]));

  // FIFO model: pops on the rising edge of fifo_rd
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int k = 0; k < 4; k++)
      if (rd_v[k]) begin
        rd_total[k]++;
        prev_rd = last_rd;
        last_rd = cyc;
      end
    if (|rd_v) begin
      if (fifo_empty) rd_bad++;
      else void'(q.pop_front());
    end
    fifo_empty = q.size() == 0;
    fifo_data  = fifo_empty ? 8'h00 : q[0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    else passed++;
  endtask

  task automatic push(input logic [7:0] v);
    q.push_back(v);
    fifo_empty = 1'b0;
    fifo_data  = q[0];
  endtask

  task automatic wait_start(input int k, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_v[k] !== 1'b0 && n < 10);
    check({tag, "_start"}, tx_v[k], 0);
  endtask

  task automatic capture(input int k, input int nbits, input int drop_at);
    logic first = 1'b1;
    cap_bits = '0; cap_glitch = 0; cap_busy = 0; cap_rd = 0; cap_done = 0;
    for (int c = 0; c < nbits * 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c == drop_at) en_v[k] = 1'b0;
      if (c % 4 == 0) first = tx_v[k];
      else if (tx_v[k] !== first) cap_glitch++;
      cap_bits[c/4] = first;
      cap_busy += int'(busy_v[k]);
      cap_rd   += int'(rd_v[k]);
      cap_done += int'(done_v[k]);
    end
    @(negedge clk);
    end_tx = tx_v[k]; end_done = done_v[k]; end_busy = busy_v[k];
  endtask

  task automatic frame_checks(input string tag, input logic [15:0] exp, input int nbits);
    check({tag, "_bits"}, cap_bits, exp);
    check({tag, "_glitch"}, cap_glitch, 0);
    check({tag, "_busy_clks"}, cap_busy, nbits * 4);
    check({tag, "_rd_pulses"}, cap_rd, 1);
    check({tag, "_done_early"}, cap_done, 0);
    check({tag, "_done_end"}, end_done, 1);
    check({tag, "_busy_end"}, end_busy, 0);
    check({tag, "_tx_end"}, end_tx, 1);
  endtask

  initial begin
    int bad, rd0;
    rst = 1'b1; en_v = '0; fifo_empty = 1'b1; fifo_data = '0;
    #1;
    check("rst_tx", tx_v, 4'hF);
    check("rst_rd", rd_v, 0);
    check("rst_busy", busy_v, 0);
    check("rst_done", done_v, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // 0x55, 8N1
    push(8'h55); en_v[0] = 1'b1;
    wait_start(0, "a55");
    capture(0, 10, -1);
    en_v[0] = 1'b0;
    frame_checks("a55", 16'h02AA, 10);
    // 0x07 with even and odd parity
    @(negedge clk); push(8'h07); en_v[1] = 1'b1;
    wait_start(1, "even07");
    capture(1, 11, -1);
    en_v[1] = 1'b0;
    frame_checks("even07", 16'h060E, 11);
    @(negedge clk); push(8'h07); en_v[2] = 1'b1;
    wait_start(2, "odd07");
    capture(2, 11, -1);
    en_v[2] = 1'b0;
    frame_checks("odd07", 16'h040E, 11);
    // back-to-back 0xA5, 0x3C with even parity and two stop bits
    @(negedge clk); push(8'hA5); push(8'h3C); en_v[3] = 1'b1;
    wait_start(3, "b2b_a5");
    capture(3, 12, -1);
    frame_checks("b2b_a5", 16'h0D4A, 12);
    @(negedge clk);
    check("b2b_mark_clks", tx_v[3], 0);
    capture(3, 12, -1);
    en_v[3] = 1'b0;
    frame_checks("b2b_3c", 16'h0C78, 12);
    check("b2b_rd_gap", last_rd - prev_rd, 49);
    // async reset during data bit 3 of 0xF0
    @(negedge clk); push(8'hF0); en_v[0] = 1'b1;
    wait_start(0, "rstf0");
    repeat (17) @(negedge clk);
    check("rstf0_bit3", tx_v[0], 0);
    #2 rst = 1'b1;
    #1;
    check("rstf0_tx", tx_v[0], 1);
    check("rstf0_rd", rd_v[0], 0);
    check("rstf0_busy", busy_v[0], 0);
    check("rstf0_done", done_v[0], 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    rd0 = rd_total[0]; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    check("rstf0_quiet", bad, 0);
    check("rstf0_no_rd", rd_total[0] - rd0, 0);
    push(8'h81);
    wait_start(0, "post81");
    capture(0, 10, -1);
    frame_checks("post81", 16'h0302, 10);
    // enable low with data present, then enable dropped mid-frame
    en_v[0] = 1'b0;
    @(negedge clk); push(8'h12);
    rd0 = rd_total[0]; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    check("stall_quiet", bad, 0);
    check("stall_no_rd", rd_total[0] - rd0, 0);
    en_v[0] = 1'b1;
    wait_start(0, "drop12");
    capture(0, 10, 10);
    frame_checks("drop12", 16'h0224, 10);
    @(negedge clk); push(8'h34);
    rd0 = rd_total[0]; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) bad++;
    end
    check("drop_quiet", bad, 0);
    check("drop_no_rd", rd_total[0] - rd0, 0);
    check("rd_while_empty", rd_bad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
